// File: rtl/noc_flit_collector.sv
// Packet sink for a mesh router Local port. It measures per-packet latency, queues one record
// per packet and keeps aggregate statistics. Defining COLLECTOR_LOG_EN adds a per-commit text log.
module noc_flit_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int MODULE_ID  = 0,
    parameter int ID_W       = 6,
    parameter int PKTID_W    = 10,
    parameter int LEN_W      = 4,
    parameter int TS_W       = 32,
    parameter int REC_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    input  logic                  ReqUpStr,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [PKTID_W-1:0]    rec_pktid,
    output logic [ID_W-1:0]       rec_src,
    output logic [LEN_W-1:0]      rec_len,
    output logic [TS_W-1:0]       rec_latency,
    output logic                  rec_err,
    output logic [31:0]           pkt_count,
    output logic [31:0]           flit_count,
    output logic [15:0]           misroute_count,
    output logic [TS_W-1:0]       max_latency
);

    localparam int PTR_W = $clog2(REC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = PKTID_W + ID_W + LEN_W + TS_W + 1;

    typedef enum logic [1:0] {HEAD, STAMP, BODY} state_t;

    state_t              state_q;
    logic                gnt_q;
    logic [TS_W-1:0]     cycleCnt_q;
    logic [PKTID_W-1:0]  pktId_q;
    logic [ID_W-1:0]     src_q;
    logic [ID_W-1:0]     dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    remaining_q;
    logic [TS_W-1:0]     latency_q;
    logic [31:0]         pktCount_q;
    logic [31:0]         flitCount_q;
    logic [15:0]         misroute_q;
    logic [TS_W-1:0]     maxLat_q;

    logic [REC_W-1:0]    fifoMem_q [REC_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q;
    logic [PTR_W-1:0]    rdPtr_q;
    logic [CNT_W-1:0]    count_q;

    logic [PKTID_W-1:0]  hdrPktId;
    logic [ID_W-1:0]     hdrSrc;
    logic [ID_W-1:0]     hdrDst;
    logic [LEN_W-1:0]    hdrLen;
    logic [TS_W-1:0]     stampLat;
    logic                accept;
    logic                commit;
    logic                commitErr;
    logic [TS_W-1:0]     commitLat_d;
    logic                pop;
    logic                unusedBits;

    assign hdrPktId   = PacketIn[DATA_WIDTH-1 -: PKTID_W];
    assign hdrSrc     = PacketIn[DATA_WIDTH-1-PKTID_W -: ID_W];
    assign hdrDst     = PacketIn[DATA_WIDTH-1-PKTID_W-ID_W -: ID_W];
    assign hdrLen     = PacketIn[DATA_WIDTH-1-PKTID_W-2*ID_W -: LEN_W];
    assign stampLat   = cycleCnt_q - PacketIn[TS_W-1:0];
    assign unusedBits = ^PacketIn;

    assign UpStrFull = (count_q == CNT_W'(REC_DEPTH));
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_ready;
    assign commitErr = (dst_q != ID_W'(MODULE_ID));

    // A record slot is reserved when the header is admitted, so only headers see backpressure.
    always_comb begin
        accept      = ReqUpStr && !gnt_q && ((state_q != HEAD) || !UpStrFull);
        commit      = 1'b0;
        commitLat_d = latency_q;
        if (accept) begin
            case (state_q)
                STAMP: begin
                    commitLat_d = stampLat;
                    commit      = (len_q == '0);
                end
                BODY:    commit = (remaining_q == LEN_W'(1));
                default: commit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HEAD;
            gnt_q       <= 1'b0;
            cycleCnt_q  <= '0;
            pktId_q     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            latency_q   <= '0;
            pktCount_q  <= '0;
            flitCount_q <= '0;
            misroute_q  <= '0;
            maxLat_q    <= '0;
        end else begin
            cycleCnt_q <= cycleCnt_q + TS_W'(1);
            gnt_q      <= accept;
            if (accept) begin
                flitCount_q <= flitCount_q + 32'd1;
                case (state_q)
                    HEAD: begin
                        pktId_q     <= hdrPktId;
                        src_q       <= hdrSrc;
                        dst_q       <= hdrDst;
                        len_q       <= hdrLen;
                        remaining_q <= hdrLen;
                        state_q     <= STAMP;
                    end
                    STAMP: begin
                        latency_q <= stampLat;
                        state_q   <= (len_q == '0) ? HEAD : BODY;
                    end
                    BODY: begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) state_q <= HEAD;
                    end
                    default: state_q <= HEAD;
                endcase
            end
            if (commit) begin
                pktCount_q <= pktCount_q + 32'd1;
                if (commitErr && (misroute_q != 16'hFFFF)) misroute_q <= misroute_q + 16'd1;
                if (commitLat_d > maxLat_q) maxLat_q <= commitLat_d;
            end
        end
    end

    // Record FIFO; the head entry drives rec_* directly from storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REC_DEPTH; i++) fifoMem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (commit) begin
                fifoMem_q[wrPtr_q] <= {pktId_q, src_q, len_q, commitLat_d, commitErr};
                wrPtr_q            <= wrPtr_q + PTR_W'(1);
            end
            if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({commit, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign {rec_pktid, rec_src, rec_len, rec_latency, rec_err} = fifoMem_q[rdPtr_q];

    assign GntUpStr       = gnt_q;
    assign pkt_count      = pktCount_q;
    assign flit_count     = flitCount_q;
    assign misroute_count = misroute_q;
    assign max_latency    = maxLat_q;

`ifdef COLLECTOR_LOG_EN
    // Per-commit log line reported on the simulator console.
    always @(posedge clk) begin
        if (reset && commit)
            $display("Collector_Log_%0d: %0t; %0d; %0d; %0d; %0d; %0d; %0d; %0d", MODULE_ID,
                     $time, cycleCnt_q, src_q, MODULE_ID, pktId_q, len_q, commitLat_d, commitErr);
    end
`endif

endmodule
